// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
//
// Frames a byte stream pulled from the UART RX request interface into fixed-length graphics
// commands, presents each one on a valid/ready output and answers the host with a one-byte
// ACK (0x06) or NAK (0x15) through the UART TX request interface.
//
// Commands (payload bytes MSB first):
//   0x01 NOP    no payload, ACK only, nothing issued downstream
//   0x02 CLEAR  colour
//   0x03 PIXEL  x[15:8], x[7:0], y[15:8], y[7:0], colour
//   other       io_err pulse + NAK, byte discarded
//
// Parameters
//   TIMEOUT  idle cycles tolerated between payload bytes before the command is dropped (>= 2)
//   ACK_EN   1: send ACK/NAK replies, 0: never raise io_txReq_req
//
// Ports
//   clock, reset      sole clock, synchronous active-high reset
//   io_rxReq_*        pull interface to the UART RX FIFO (req out, ready/done/pkt in)
//   io_txReq_*        reply interface to the UART TX (req/pkt out, ready in)
//   io_cmd_*          decoded command, valid/ready handshake
//   io_err            one-cycle pulse on unknown opcode or payload timeout
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT = 1024,
  parameter bit          ACK_EN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_rxReq_pkt,
  output logic        io_rxReq_req,
  input  logic        io_rxReq_ready,
  input  logic        io_rxReq_done,
  output logic [7:0]  io_txReq_pkt,
  output logic        io_txReq_req,
  input  logic        io_txReq_ready,
  output logic        io_cmd_valid,
  input  logic        io_cmd_ready,
  output logic [7:0]  io_cmd_op,
  output logic [15:0] io_cmd_x,
  output logic [15:0] io_cmd_y,
  output logic [7:0]  io_cmd_color,
  output logic        io_err
);

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StIssue,
    StReply
  } state_e;

  localparam logic [7:0] OpNop   = 8'h01;
  localparam logic [7:0] OpClear = 8'h02;
  localparam logic [7:0] OpPixel = 8'h03;
  localparam logic [7:0] ByteAck = 8'h06;
  localparam logic [7:0] ByteNak = 8'h15;

  localparam int unsigned      CntW       = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0]  TimeoutCnt = CntW'(TIMEOUT);

  // With replies disabled every path that would reply goes straight back to fetching.
  localparam state_e ReplyOrFetch = ACK_EN ? StReply : StFetch;

  state_e          state_q, state_d;
  logic [2:0]      rem_q, rem_d;      // payload bytes still expected; 0 means next byte is opcode
  logic [7:0]      op_q, op_d;
  logic [31:0]     asm_q, asm_d;      // up to four earlier payload bytes, newest in [7:0]
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            rx_req_q, rx_req_d;
  logic            err_q, err_d;
  logic            nak_q, nak_d;
  logic            load_cmd;
  logic            capture;
  logic            counting;
  logic            timed_out;

  logic [7:0]      cmd_op_q;
  logic [15:0]     cmd_x_q;
  logic [15:0]     cmd_y_q;
  logic [7:0]      cmd_color_q;

  assign capture  = (state_q == StWait) && io_rxReq_done;
  assign counting = (rem_q != 3'd0) && ((state_q == StFetch) || (state_q == StWait));
  assign cnt_inc  = cnt_q + CntW'(1);

  // cnt_q equals the number of cycles since the last captured byte (the capture loads 1), so
  // deciding when the increment reaches TIMEOUT puts the registered io_err and the move to
  // REPLY exactly TIMEOUT cycles after that byte's done.
  assign timed_out = counting && (cnt_inc == TimeoutCnt);

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    op_d         = op_q;
    asm_d        = asm_q;
    cnt_d        = counting ? cnt_inc : cnt_q;
    rx_req_d     = 1'b0;
    err_d        = 1'b0;
    nak_d        = nak_q;
    load_cmd     = 1'b0;
    io_txReq_req = 1'b0;

    // A byte landing in the same cycle as the deadline still counts.
    if (timed_out && !capture) begin
      rem_d   = 3'd0;
      cnt_d   = '0;
      err_d   = 1'b1;
      nak_d   = 1'b1;
      state_d = ReplyOrFetch;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (io_rxReq_ready) begin
            rx_req_d = 1'b1;
            state_d  = StWait;
          end
        end

        StWait: begin
          if (capture) begin
            cnt_d = CntW'(1);
            if (rem_q == 3'd0) begin
              op_d  = io_rxReq_pkt;
              asm_d = '0;
              case (io_rxReq_pkt)
                OpNop: begin
                  nak_d   = 1'b0;
                  state_d = ReplyOrFetch;
                end
                OpClear: begin
                  rem_d   = 3'd1;
                  state_d = StFetch;
                end
                OpPixel: begin
                  rem_d   = 3'd5;
                  state_d = StFetch;
                end
                default: begin
                  err_d   = 1'b1;
                  nak_d   = 1'b1;
                  state_d = ReplyOrFetch;
                end
              endcase
            end else begin
              asm_d = {asm_q[23:0], io_rxReq_pkt};
              rem_d = rem_q - 3'd1;
              if (rem_q == 3'd1) begin
                load_cmd = 1'b1;
                state_d  = StIssue;
              end else begin
                state_d = StFetch;
              end
            end
          end
        end

        StIssue: begin
          if (io_cmd_ready) begin
            nak_d   = 1'b0;
            state_d = ReplyOrFetch;
          end
        end

        StReply: begin
          if (io_txReq_ready || !ACK_EN) begin
            io_txReq_req = ACK_EN;
            state_d      = StFetch;
          end
        end

        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StFetch;
      rem_q       <= 3'd0;
      op_q        <= 8'h00;
      asm_q       <= '0;
      cnt_q       <= '0;
      rx_req_q    <= 1'b0;
      err_q       <= 1'b0;
      nak_q       <= 1'b0;
      cmd_op_q    <= 8'h00;
      cmd_x_q     <= 16'h0000;
      cmd_y_q     <= 16'h0000;
      cmd_color_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      asm_q    <= asm_d;
      cnt_q    <= cnt_d;
      rx_req_q <= rx_req_d;
      err_q    <= err_d;
      nak_q    <= nak_d;
      // Fields are only touched here, so they stay put for the whole valid window.
      if (load_cmd) begin
        cmd_op_q    <= op_q;
        cmd_color_q <= io_rxReq_pkt;
        if (op_q == OpPixel) begin
          cmd_x_q <= asm_q[31:16];
          cmd_y_q <= asm_q[15:0];
        end else begin
          cmd_x_q <= 16'h0000;
          cmd_y_q <= 16'h0000;
        end
      end
    end
  end

  assign io_rxReq_req = rx_req_q;
  assign io_err       = err_q;
  assign io_cmd_valid = (state_q == StIssue);
  assign io_cmd_op    = cmd_op_q;
  assign io_cmd_x     = cmd_x_q;
  assign io_cmd_y     = cmd_y_q;
  assign io_cmd_color = cmd_color_q;
  assign io_txReq_pkt = (state_q == StReply) ? (nak_q ? ByteNak : ByteAck) : 8'h00;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: a main instance (TIMEOUT=16, replies on) and a second
// instance with replies disabled. Byte streams are built from the command table; expected
// commands, reply bytes and error counts go into queues/counters that monitors check.
module tb_uart_cmd_decoder;

  localparam int unsigned TO = 16;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  color;
  } cmd_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [7:0]  rx_pkt;
  logic        rx_req, rx_ready, rx_done;
  logic [7:0]  tx_pkt;
  logic        tx_req, tx_ready;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_op, cmd_color;
  logic [15:0] cmd_x, cmd_y;
  logic        err;

  logic [7:0]  rx2_pkt;
  logic        rx2_req, rx2_ready, rx2_done;
  logic [7:0]  tx2_pkt;
  logic        tx2_req;
  logic        cmd2_valid;
  logic [7:0]  cmd2_op, cmd2_color;
  logic [15:0] cmd2_x, cmd2_y;
  logic        err2;

  uart_cmd_decoder #(.TIMEOUT(TO), .ACK_EN(1'b1)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_rxReq_pkt  (rx_pkt),
    .io_rxReq_req  (rx_req),
    .io_rxReq_ready(rx_ready),
    .io_rxReq_done (rx_done),
    .io_txReq_pkt  (tx_pkt),
    .io_txReq_req  (tx_req),
    .io_txReq_ready(tx_ready),
    .io_cmd_valid  (cmd_valid),
    .io_cmd_ready  (cmd_ready),
    .io_cmd_op     (cmd_op),
    .io_cmd_x      (cmd_x),
    .io_cmd_y      (cmd_y),
    .io_cmd_color  (cmd_color),
    .io_err        (err)
  );

  uart_cmd_decoder #(.TIMEOUT(TO), .ACK_EN(1'b0)) dut2 (
    .clock         (clock),
    .reset         (reset),
    .io_rxReq_pkt  (rx2_pkt),
    .io_rxReq_req  (rx2_req),
    .io_rxReq_ready(rx2_ready),
    .io_rxReq_done (rx2_done),
    .io_txReq_pkt  (tx2_pkt),
    .io_txReq_req  (tx2_req),
    .io_txReq_ready(1'b1),
    .io_cmd_valid  (cmd2_valid),
    .io_cmd_ready  (1'b1),
    .io_cmd_op     (cmd2_op),
    .io_cmd_x      (cmd2_x),
    .io_cmd_y      (cmd2_y),
    .io_cmd_color  (cmd2_color),
    .io_err        (err2)
  );

  int total = 0;
  int bad   = 0;

  cmd_t       exp_cmd_q[$];
  cmd_t       exp_cmd2_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx2_q[$];

  int cyc = 0;
  int last_done_cyc = 0, hs_cyc = 0, tx_cyc = 0, err_cyc = 0;
  int pull_cnt = 0, done_cnt = 0, cmd_cnt = 0, tx_cnt = 0, err_cnt = 0, exp_err = 0;
  int tx2_cnt = 0, err2_cnt = 0, exp_err2 = 0;
  int cmd_ready_mode = 1;  // 0 low, 1 high, 2 random
  int tx_ready_mode  = 1;
  logic prev_rx_req = 1'b0, prev_valid = 1'b0;
  cmd_t mon_e, mon2_e;
  logic [7:0] mon_tx;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit second, input logic [7:0] b);
    if (second) rx2_q.push_back(b);
    else rx_q.push_back(b);
  endtask

  // Reference model: byte stream and expected outcome straight from the command table.
  task automatic send_cmd(input bit second, input logic [7:0] op, input logic [39:0] pl);
    cmd_t c;
    bit   known;
    push(second, op);
    known = (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
    if (op == 8'h02) begin
      push(second, pl[7:0]);
      c = '{op: op, x: 16'h0, y: 16'h0, color: pl[7:0]};
    end else if (op == 8'h03) begin
      for (int k = 4; k >= 0; k--) push(second, pl[8*k +: 8]);
      c = cmd_t'({op, pl});
    end
    if (op == 8'h02 || op == 8'h03) begin
      if (second) exp_cmd2_q.push_back(c);
      else exp_cmd_q.push_back(c);
    end
    if (!known) begin
      if (second) exp_err2++;
      else exp_err++;
    end
    if (!second) exp_tx_q.push_back(known ? 8'h06 : 8'h15);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((rx_q.size() != 0 || rx2_q.size() != 0 || exp_cmd_q.size() != 0 ||
            exp_tx_q.size() != 0 || exp_cmd2_q.size() != 0) && n < budget) begin
      @(posedge clock);
      n++;
    end
    check({name, "_drain"}, 64'(n < budget), 1);
    repeat (6) @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_req"}, rx_req, 0);
    check({tag, "_tx_req"}, tx_req, 0);
    check({tag, "_tx_pkt"}, tx_pkt, 0);
    check({tag, "_valid"}, cmd_valid, 0);
    check({tag, "_fields"}, {cmd_op, cmd_x, cmd_y, cmd_color}, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Handshake-input drivers.
  initial begin
    cmd_ready = 1'b0;
    tx_ready  = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      cmd_ready = (cmd_ready_mode == 2) ? ($urandom_range(0, 3) != 0) : (cmd_ready_mode == 1);
      tx_ready  = (tx_ready_mode == 2) ? ($urandom_range(0, 2) != 0) : (tx_ready_mode == 1);
    end
  end

  // UART RX FIFO model for the main instance: answers each pull 1..3 cycles later.
  initial begin
    int lat;
    rx_done = 1'b0; rx_pkt = 8'h00; rx_ready = 1'b0;
    forever begin
      @(negedge clock);
      rx_ready = (rx_q.size() != 0);
      if (rx_req && !reset) begin
        lat = $urandom_range(1, 3);
        repeat (lat) @(posedge clock);
        #1;
        if (rx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rx_pull_empty: got pull want none (cycle %0d)", cyc);
        end else begin
          rx_pkt  = rx_q.pop_front();
          rx_done = 1'b1;
        end
        rx_ready = (rx_q.size() != 0);
        @(posedge clock);
        #1;
        rx_done = 1'b0;
      end
    end
  end

  // Same FIFO model for the reply-less instance.
  initial begin
    int lat;
    rx2_done = 1'b0; rx2_pkt = 8'h00; rx2_ready = 1'b0;
    forever begin
      @(negedge clock);
      rx2_ready = (rx2_q.size() != 0);
      if (rx2_req && !reset) begin
        lat = $urandom_range(1, 3);
        repeat (lat) @(posedge clock);
        #1;
        if (rx2_q.size() != 0) begin
          rx2_pkt  = rx2_q.pop_front();
          rx2_done = 1'b1;
        end
        rx2_ready = (rx2_q.size() != 0);
        @(posedge clock);
        #1;
        rx2_done = 1'b0;
      end
    end
  end

  // Main monitor / scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_req) begin
        pull_cnt++;
        check("rx_req_back_to_back", prev_rx_req, 0);
      end
      if (rx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (cmd_valid && !prev_valid) check("valid_latency", cyc, last_done_cyc + 1);
      if (cmd_valid && cmd_ready) begin
        hs_cyc = cyc;
        cmd_cnt++;
        if (exp_cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got %0h want none", {cmd_op, cmd_x, cmd_y, cmd_color});
        end else begin
          mon_e = exp_cmd_q.pop_front();
          check("cmd_fields", {cmd_op, cmd_x, cmd_y, cmd_color}, mon_e);
        end
      end
      if (tx_req) begin
        tx_cnt++;
        tx_cyc = cyc;
        if (exp_tx_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got %0h want none", tx_pkt);
        end else begin
          mon_tx = exp_tx_q.pop_front();
          check("tx_byte", tx_pkt, mon_tx);
        end
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      prev_rx_req = rx_req;
      prev_valid  = cmd_valid;
    end else begin
      prev_rx_req = 1'b0;
      prev_valid  = 1'b0;
    end
  end

  // Reply-less instance monitor; its cmd_ready is tied high so every valid cycle is a transfer.
  always @(negedge clock) begin
    if (!reset) begin
      if (cmd2_valid) begin
        if (exp_cmd2_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd2_unexpected: got %0h want none",
                   {cmd2_op, cmd2_x, cmd2_y, cmd2_color});
        end else begin
          mon2_e = exp_cmd2_q.pop_front();
          check("cmd2_fields", {cmd2_op, cmd2_x, cmd2_y, cmd2_color}, mon2_e);
        end
      end
      if (tx2_req) tx2_cnt++;
      if (err2) err2_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, t0, p0, e0, d0, c0, r;
    logic [7:0]  op;
    logic [39:0] pl;

    // Reset values.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    check("reset_tx2_req", tx2_req, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed PIXEL with all handshakes open.
    p0 = pull_cnt;
    send_cmd(0, 8'h03, 40'h0140_00F0_AB);
    drain("pixel", 400);
    check("pixel_pulls", pull_cnt - p0, 6);
    check("pixel_ack_latency", tx_cyc - hs_cyc, 1);

    // CLEAR with downstream stalled for 50 cycles.
    cmd_ready_mode = 0;
    @(posedge clock);
    #1;
    t0 = tx_cnt;
    send_cmd(0, 8'h02, 40'h5A);
    n = 0;
    while (!cmd_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("stall_valid_seen", 64'(n < 100), 1);
    repeat (50) begin
      @(negedge clock);
      check("stall_valid", cmd_valid, 1);
      check("stall_fields", {cmd_op, cmd_x, cmd_y, cmd_color}, 48'h02_0000_0000_5A);
    end
    check("stall_no_tx", tx_cnt - t0, 0);
    cmd_ready_mode = 1;
    drain("stall", 300);

    // Unknown opcode then NOP.
    c0 = cmd_cnt;
    send_cmd(0, 8'h7E, 40'h0);
    send_cmd(0, 8'h01, 40'h0);
    drain("unknown", 300);
    check("unknown_no_cmd", cmd_cnt - c0, 0);
    check("unknown_err", err_cnt, exp_err);

    // Payload timeout after two bytes of a PIXEL.
    push(0, 8'h03);
    push(0, 8'h00);
    exp_err++;
    exp_tx_q.push_back(8'h15);
    e0 = err_cnt;
    n  = 0;
    while (err_cnt == e0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("timeout_seen", err_cnt - e0, 1);
    check("timeout_latency", err_cyc - last_done_cyc, TO);
    drain("timeout", 300);
    send_cmd(0, 8'h03, {$urandom, 8'($urandom)});
    drain("after_timeout", 400);
    check("timeout_err", err_cnt, exp_err);

    // TX not ready: the reply holds the decoder, so no further pulls.
    tx_ready_mode = 0;
    @(posedge clock);
    #1;
    p0 = pull_cnt;
    t0 = tx_cnt;
    send_cmd(0, 8'h01, 40'h0);
    send_cmd(0, 8'h02, 40'($urandom));
    repeat (40) @(posedge clock);
    #1;
    check("txhold_no_tx", tx_cnt - t0, 0);
    check("txhold_pulls", pull_cnt - p0, 1);
    tx_ready_mode = 1;
    drain("txhold", 400);

    // Reset after three bytes of a PIXEL.
    d0 = done_cnt;
    push(0, 8'h03);
    push(0, 8'($urandom));
    push(0, 8'($urandom));
    n = 0;
    while (done_cnt < d0 + 3 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("rst_bytes_seen", done_cnt - d0, 3);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_zero("midrst");
    repeat (30) @(posedge clock);
    #1;
    check("midrst_err", err_cnt, exp_err);
    send_cmd(0, 8'h02, 40'h11);
    drain("midrst", 300);

    // Randomised mix, fed to both instances.
    cmd_ready_mode = 2;
    tx_ready_mode  = 2;
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      pl = {$urandom, 8'($urandom)};
      if (r < 2) op = 8'h01;
      else if (r < 5) op = 8'h02;
      else if (r < 9) op = 8'h03;
      else op = 8'($urandom_range(4, 255));
      send_cmd(0, op, pl);
      send_cmd(1, op, pl);
    end
    drain("random", 6000);
    cmd_ready_mode = 1;
    tx_ready_mode  = 1;

    check("final_err", err_cnt, exp_err);
    check("final_err2", err2_cnt, exp_err2);
    check("noack_tx_req", tx2_cnt, 0);
    check("leftover", exp_cmd_q.size() + exp_tx_q.size() + exp_cmd2_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
